// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit.
// Contents:
//   - Opcode constants (OP_B, OP_BR, OP_PCS, OP_HLT).
//   - Condition-code (ccc) encodings.
//   - RUN/HALT state encoding.
//   - Helper that turns the B-format imm9 into a signed byte offset.
package branch_unit_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE     = 3'b000; // Z=0
  localparam logic [2:0] CC_EQ     = 3'b001; // Z=1
  localparam logic [2:0] CC_GT     = 3'b010; // Z=0 & N=0
  localparam logic [2:0] CC_LT     = 3'b011; // N=1
  localparam logic [2:0] CC_GE     = 3'b100; // Z=1 | (Z=0 & N=0)
  localparam logic [2:0] CC_LE     = 3'b101; // N=1 | Z=1
  localparam logic [2:0] CC_OVF    = 3'b110; // V=1
  localparam logic [2:0] CC_ALWAYS = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } bu_state_e;

  // imm9 counts halfwords: sign-extend and scale to a byte offset.
  function automatic logic signed [DATA_W-1:0] b_offset(input logic [8:0] imm9);
    return signed'({{6{imm9[8]}}, imm9, 1'b0});
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Bundle of the branch unit's fetch/flag inputs and PC/control outputs.
// Modports:
//   master : core side, drives stall/instr/rs_data/flags, observes PC outputs.
//   slave  : branch unit side.
// Signals:
//   stall           hold request (no architectural update when 1)
//   instr[15:0]     instruction at pc: [15:12] opcode, [11:9] ccc, [8:0] imm9
//   rs_data[15:0]   register source for BR
//   N_Flag/Z_Flag/V_Flag  registered ALU flags
//   pc[15:0]        current PC (registered)
//   pc_plus2[15:0]  pc + 2 (combinational), PCS write-back value
//   taken           current instr is a B/BR whose condition holds
//   flush           one-cycle pulse after a committed taken branch
//   halted          1 while in HALT
interface branch_unit_if;
  import branch_unit_pkg::*;

  logic              stall;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] rs_data;
  logic              N_Flag;
  logic              Z_Flag;
  logic              V_Flag;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_plus2;
  logic              taken;
  logic              flush;
  logic              halted;

  modport master (
    output stall, instr, rs_data, N_Flag, Z_Flag, V_Flag,
    input  pc, pc_plus2, taken, flush, halted
  );

  modport slave (
    input  stall, instr, rs_data, N_Flag, Z_Flag, V_Flag,
    output pc, pc_plus2, taken, flush, halted
  );

endinterface

// File: rtl/branch_unit_cond_eval.sv
// Branch condition evaluator (purely combinational).
// Ports:
//   ccc[2:0]   condition code from the instruction
//   n_flag, z_flag, v_flag  ALU flags as presented this cycle
//   cond_true  1 when the selected condition holds
module cond_eval
  import branch_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic       v_flag,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (ccc)
      CC_NE:     cond_true = ~z_flag;
      CC_EQ:     cond_true = z_flag;
      CC_GT:     cond_true = ~z_flag & ~n_flag;
      CC_LT:     cond_true = n_flag;
      CC_GE:     cond_true = z_flag | (~z_flag & ~n_flag);
      CC_LE:     cond_true = n_flag | z_flag;
      CC_OVF:    cond_true = v_flag;
      CC_ALWAYS: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: owns the PC, the RUN/HALT state and the flush pulse.
// Branch decision is combinational on the current instr/flags; the new PC
// and flush become visible on the following cycle.
// Ports:
//   clk  sole clock (rising edge)
//   rst  synchronous active-high reset; wins over stall, HALT and branches
//   bu   branch_unit_if.slave (see interface for signal list)
// Parameters:
//   RESET_PC  PC loaded on reset
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  branch_unit_if.slave  bu
);

  logic [DATA_W-1:0]        pc_r;
  bu_state_e                state_r;
  logic                     flush_r;

  logic [3:0]               opcode;
  logic [2:0]               ccc;
  logic [8:0]               imm9;
  logic                     is_b;
  logic                     is_br;
  logic                     is_hlt;
  logic                     running;
  logic                     cond_true;
  logic                     taken_c;
  logic [DATA_W-1:0]        pc_plus2_c;
  logic signed [DATA_W-1:0] b_target_s;
  logic [DATA_W-1:0]        target_c;
  logic                     unused_rs_lsb;

  assign opcode = bu.instr[15:12];
  assign ccc    = bu.instr[11:9];
  assign imm9   = bu.instr[8:0];

  assign is_b    = (opcode == OP_B);
  assign is_br   = (opcode == OP_BR);
  assign is_hlt  = (opcode == OP_HLT);
  assign running = (state_r == ST_RUN);

  cond_eval u_cond_eval (
    .ccc       (ccc),
    .n_flag    (bu.N_Flag),
    .z_flag    (bu.Z_Flag),
    .v_flag    (bu.V_Flag),
    .cond_true (cond_true)
  );

  // Decode / target stage (combinational).
  assign pc_plus2_c = pc_r + 16'd2;
  assign b_target_s = signed'(pc_plus2_c) + b_offset(imm9);
  // BR targets are halfword aligned: the register's LSB is discarded.
  assign target_c   = is_br ? {bu.rs_data[DATA_W-1:1], 1'b0} : unsigned'(b_target_s);
  assign taken_c    = running & (is_b | is_br) & cond_true;

  assign unused_rs_lsb = bu.rs_data[0];

  // Commit stage: PC, state and flush update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      state_r <= ST_RUN;
      flush_r <= 1'b0;
    end else begin
      flush_r <= taken_c & ~bu.stall;
      if (running && !bu.stall) begin
        if (is_hlt) begin
          state_r <= ST_HALT;
        end else if (taken_c) begin
          pc_r <= target_c;
        end else begin
          pc_r <= pc_plus2_c;
        end
      end
    end
  end

  assign bu.pc       = pc_r;
  assign bu.pc_plus2 = pc_plus2_c;
  assign bu.taken    = taken_c;
  assign bu.flush    = flush_r;
  assign bu.halted   = (state_r == ST_HALT);

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: table of single-instruction vectors
// plus hand-written reset, stall, halt and condition-sweep sequences.
module tb_branch_unit;
  import branch_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_unit_if bu ();

  branch_unit #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bu  (bu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start_pc;
    logic [15:0] instr;
    logic [15:0] rs;
    logic        n;
    logic        z;
    logic        v;
    logic        e_taken;
    logic [15:0] e_pp2;
    logic [15:0] e_pc;
    logic        e_flush;
  } vec_t;

  vec_t vecs [12];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic exp_cond(input logic [2:0] c, input logic n, input logic z, input logic v);
    case (c)
      3'b000:  return (z == 1'b0);
      3'b001:  return (z == 1'b1);
      3'b010:  return (z == 1'b0) && (n == 1'b0);
      3'b011:  return (n == 1'b1);
      3'b100:  return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
      3'b101:  return (n == 1'b1) || (z == 1'b1);
      3'b110:  return (v == 1'b1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive(input logic [15:0] ins, input logic [15:0] rs, input logic st,
                       input logic n, input logic z, input logic v);
    bu.instr   = ins;
    bu.rs_data = rs;
    bu.stall   = st;
    bu.N_Flag  = n;
    bu.Z_Flag  = z;
    bu.V_Flag  = v;
  endtask

  // Jump to addr with an unconditional BR; returns at the next negedge.
  task automatic set_pc(input logic [15:0] addr);
    drive(16'hDE00, addr, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //               start    instr    rs       n     z     v     taken pp2      next pc  flush
    vecs[0]  = '{16'h0010, 16'hC3FE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0012, 16'h000E, 1'b1};
    vecs[1]  = '{16'h0010, 16'hC3FE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0012, 1'b0};
    vecs[2]  = '{16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0040, 16'hE000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b0};
    vecs[4]  = '{16'h0100, 16'hCC05, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0102, 16'h010C, 1'b1};
    vecs[5]  = '{16'h0100, 16'hC405, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, 16'h0102, 1'b0};
    vecs[6]  = '{16'h0200, 16'hD600, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0202, 16'h8000, 1'b1};
    vecs[7]  = '{16'h0200, 16'hD000, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0202, 16'h0202, 1'b0};
    vecs[8]  = '{16'h1000, 16'hCEFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1002, 16'h1200, 1'b1};
    vecs[9]  = '{16'h0000, 16'hCF00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hFE02, 1'b1};
    vecs[10] = '{16'hFFF0, 16'hCE10, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF2, 16'h0012, 1'b1};
    vecs[11] = '{16'h0300, 16'hB123, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0302, 16'h0302, 1'b0};

    // Reset and three sequential instructions.
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk16("reset_pc", bu.pc, 16'h0000);
    chk1("reset_flush", bu.flush, 1'b0);
    chk1("reset_halted", bu.halted, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(16'h1000 + 16'(i), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk16($sformatf("seq%0d_pc", i), bu.pc, 16'(2 * i));
      chk1($sformatf("seq%0d_flush", i), bu.flush, 1'b0);
    end

    // Table-driven single-instruction vectors.
    for (int i = 0; i < 12; i++) begin
      set_pc(vecs[i].start_pc);
      drive(vecs[i].instr, vecs[i].rs, 1'b0, vecs[i].n, vecs[i].z, vecs[i].v);
      #1;
      chk16($sformatf("v%0d_pc_before", i), bu.pc, vecs[i].start_pc);
      chk1($sformatf("v%0d_taken", i), bu.taken, vecs[i].e_taken);
      chk16($sformatf("v%0d_pc_plus2", i), bu.pc_plus2, vecs[i].e_pp2);
      @(negedge clk);
      chk16($sformatf("v%0d_next_pc", i), bu.pc, vecs[i].e_pc);
      chk1($sformatf("v%0d_flush", i), bu.flush, vecs[i].e_flush);
    end

    // BR under a two-cycle stall.
    set_pc(16'h0300);
    drive(16'hDE00, 16'h1235, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk1($sformatf("stall%0d_taken", i), bu.taken, 1'b1);
      @(negedge clk);
      chk16($sformatf("stall%0d_pc", i), bu.pc, 16'h0300);
      chk1($sformatf("stall%0d_flush", i), bu.flush, 1'b0);
    end
    bu.stall = 1'b0;
    @(negedge clk);
    chk16("stall_release_pc", bu.pc, 16'h1234);
    chk1("stall_release_flush", bu.flush, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("stall_after_pc", bu.pc, 16'h1236);
    chk1("stall_after_flush", bu.flush, 1'b0);

    // Exhaustive condition sweep; stall keeps state still.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        drive({OP_B, 3'(c), 9'h000}, 16'h0000, 1'b1, f[2], f[1], f[0]);
        #1;
        chk1($sformatf("cond_c%0d_nzv%0d", c, f), bu.taken, exp_cond(3'(c), f[2], f[1], f[0]));
      end
    end
    @(negedge clk);

    // HLT while stalled must not halt.
    set_pc(16'h0050);
    drive({OP_HLT, 12'h000}, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("hlt_stalled_pc", bu.pc, 16'h0050);
    chk1("hlt_stalled_halted", bu.halted, 1'b0);

    // HLT, then ten cycles of arbitrary instructions.
    set_pc(16'h0020);
    drive({OP_HLT, 12'h000}, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("halt_halted", bu.halted, 1'b1);
    chk16("halt_pc", bu.pc, 16'h0020);
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0:       drive(16'hCE04, 16'h0000, 1'(i % 2), 1'b0, 1'b1, 1'b0);
        1:       drive(16'hDE00, 16'h5678, 1'(i % 2), 1'b1, 1'b0, 1'b1);
        2:       drive(16'h2345, 16'h0000, 1'(i % 2), 1'b0, 1'b0, 1'b0);
        default: drive(16'hF000, 16'h0000, 1'(i % 2), 1'b0, 1'b0, 1'b0);
      endcase
      #1;
      chk1($sformatf("halt%0d_taken", i), bu.taken, 1'b0);
      @(negedge clk);
      chk16($sformatf("halt%0d_pc", i), bu.pc, 16'h0020);
      chk1($sformatf("halt%0d_halted", i), bu.halted, 1'b1);
      chk1($sformatf("halt%0d_flush", i), bu.flush, 1'b0);
    end

    // Reset out of HALT with stall and a taken-looking branch present.
    rst = 1'b1;
    drive(16'hDE00, 16'h7770, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("halt_rst_pc", bu.pc, 16'h0000);
    chk1("halt_rst_halted", bu.halted, 1'b0);
    chk1("halt_rst_flush", bu.flush, 1'b0);
    rst = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("post_rst_pc", bu.pc, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
- One clock; reset is synchronous and active-high.
- REQ-001: Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  synchronous active-high reset.
- REQ-004: stall  input  1  hold request; when 1, no architectural state updates.
- REQ-005: instr  input  16  instruction fetched at pc; [15:12] opcode, [11:9] ccc, [8:0] imm9.
- REQ-006: rs_data  input  16  register-source value for BR.
- REQ-007: N_Flag, Z_Flag, V_Flag  input  1 each  registered flags from the ALU.
- REQ-008: pc  output  16  current PC (registered).
- REQ-009: pc_plus2  output  16  pc + 2 mod 2^16 (combinational); PCS write-back value.
- REQ-010: taken  output  1  combinational; current instr is B/BR with condition true.
- REQ-011: flush  output  1  registered one-cycle pulse after a taken branch is committed.
- REQ-012: halted  output  1  1 while in HALT state.

Function
- REQ-013: Opcodes decoded: B=4'b1100, BR=4'b1101, PCS=4'b1110, HLT=4'b1111; all others are sequential.
- REQ-014: Condition ccc: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
- REQ-015: Conditions use flag input values present in the same cycle; flags written by the same-cycle ALU op are not forwarded.
- REQ-016: B target = pc_plus2 + (sign-extended imm9 << 1), mod 2^16.
- REQ-017: BR target = {rs_data[15:1], 1'b0}.
- REQ-018: FSM states RUN, HALT; RUN -> HALT when opcode=HLT and stall=0; HALT exits only on rst.
- REQ-019: In RUN with stall=0: pc <= target if taken, else pc <= pc_plus2; HLT leaves pc unchanged.
- REQ-020: In RUN with stall=1: pc, state, flush hold/clear as follows -- pc and state unchanged, flush <= 0.
- REQ-021: flush <= taken & ~stall & (state==RUN); flush is 0 in all other cycles.
- REQ-022: In HALT: pc frozen, taken forced 0, flush 0, halted 1, instr ignored.
- REQ-023: PC arithmetic wraps: pc=16'hFFFE, non-branch -> 16'h0000.
- REQ-024: Latency: branch decision combinational in cycle N; new pc and flush visible in cycle N+1.

Reset
- REQ-025: On rst=1 at a clock edge: pc <= RESET_PC, state <= RUN, flush <= 0; halted reads 0 next cycle.
- REQ-026: rst has priority over stall, HALT, and any in-flight branch.

Structure
- REQ-027: Shared package holds opcode constants (OP_B, OP_BR, OP_PCS, OP_HLT), ccc encodings, and the RUN/HALT state encoding.
- REQ-028: One sub-module, cond_eval: combinational, inputs ccc/N/Z/V, output cond_true.
- REQ-029: branch_unit holds only pc register, state register, flush register, and target muxing.

Verification
- REQ-030: Reset, then 3 non-branch instrs, stall=0 -> pc 0000,0002,0004,0006; flush 0.
- REQ-031: pc=0010, B ccc=001 imm9=9'h1FE, Z=1 -> taken=1, next pc=000E, flush=1 for one cycle; same with Z=0 -> pc=0012, flush 0.
- REQ-032: BR ccc=111 rs_data=16'h1235 with stall=1 for 2 cycles then 0 -> pc held 2 cycles, then 1234, single flush pulse.
- REQ-033: pc=FFFE, non-branch -> pc=0000; PCS at pc=0040 -> pc_plus2=0042.
- REQ-034: HLT at pc=0020 -> halted=1, pc stays 0020 for 10 cycles regardless of instr; rst -> pc=RESET_PC, halted=0.
- REQ-035: ccc=110 with V=1,N=0,Z=0 taken; ccc=010 with N=1 not taken; exhaustive cond_eval sweep of 8 ccc x 8 flag combos matches REQ-014.
